// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch sequencer feeding the UART transmitter
// Holds up to DEPTH host bytes and hands them one at a time to the transmitter.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_active,
    input  logic              done_tx,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   count_nxt;

    // A pop in the same cycle never frees room for a write while full.
    assign wr_ready  = !full;
    assign push      = wr_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            // done_tx wins here so a frame shorter than the busy handshake is not missed
            WAIT_BUSY: begin
                if (done_tx)        state_nxt = IDLE;
                else if (tx_active) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (done_tx) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            tx_start <= (state_nxt == LAUNCH);
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == (ADDR_W+1)'(DEPTH));
            if (push) begin
                wp <= wp + ADDR_W'(1);
            end
            if (pop) begin
                tx_data <= mem[rp];
                rp      <= rp + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wp] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
// Queue-based reference model plus a simple transmitter model driven once per cycle.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_active;
    logic          done_tx;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .done_tx   (done_tx),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic [AW:0] cnt;
        logic        emp;
        logic        ful;
        logic        ts;
        logic [7:0]  td;
    } vec_t;

    vec_t        vt [7];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          launches = 0;
    int          base;
    int          total;
    int          n;
    bit          found;
    bit          acc_pred;
    logic [7:0]  m_q [$];
    logic [7:0]  sent [$];
    logic [7:0]  exp_q [$];
    bit          xmt_run = 0;
    bit          xmt_stale = 0;
    bit          stall = 0;
    bit          expect_launch = 0;
    int          xmt_t = 0;
    int          frame_len = 20;
    logic [7:0]  xmt_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: edge, then update model/transmitter and compare at the falling edge.
    task automatic tick();
        bit         acc;
        bit         had;
        logic [7:0] exp_b;
        acc = wr_valid && !rst && (m_q.size() < DEPTH);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_q.delete();
            expect_launch = 0;
            if (xmt_run) xmt_stale = 1;
        end else if (acc) begin
            m_q.push_back(wr_data);
        end
        if (expect_launch) check("back_to_back_launch", 32'(tx_start), 32'd1);
        expect_launch = 0;
        if (tx_start) begin
            launches++;
            check("launch_while_busy", 32'(xmt_run), 32'd0);
            had = (m_q.size() > 0);
            check("launch_nonempty", 32'(had), 32'd1);
            exp_b = had ? m_q.pop_front() : 8'h00;
            check("tx_data_order", 32'(tx_data), 32'(exp_b));
            xmt_run   = 1;
            xmt_stale = 0;
            xmt_t     = 0;
            xmt_byte  = tx_data;
            sent.push_back(tx_data);
        end else if (xmt_run) begin
            xmt_t++;
            if (!xmt_stale) check("tx_data_stable", 32'(tx_data), 32'(xmt_byte));
            if (done_tx) begin
                done_tx = 0;
                xmt_run = 0;
                if (m_q.size() > 0 && !xmt_stale) expect_launch = 1;
            end else if (xmt_t >= frame_len && !stall) begin
                done_tx   = 1;
                tx_active = 0;
            end else if (xmt_t >= 1) begin
                tx_active = 1;
            end
        end
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("wr_ready", 32'(wr_ready), 32'(m_q.size() != DEPTH));
    endtask

    task automatic drain(input int max);
        int k = 0;
        wr_valid = 0;
        stall    = 0;
        while ((m_q.size() > 0 || xmt_run) && k < max) begin
            tick();
            k++;
        end
        check("drain_done", 32'(m_q.size() > 0 || xmt_run), 32'd0);
    endtask

    task automatic check_sent(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, 32'(sent.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < sent.size(); i++)
            check(name, 32'(sent[i]), 32'(exp[i]));
    endtask

    task automatic reset_dut();
        rst      = 1;
        wr_valid = 0;
        tick();
        rst      = 0;
        sent.delete();
        launches = 0;
    endtask

    initial begin
        rst       = 1;
        wr_valid  = 0;
        wr_data   = 8'h00;
        tx_active = 0;
        done_tx   = 0;

        // reset with writes pending, single byte launch latency, queued bytes behind it
        vt[0] = {1'b1, 1'b1, 8'h11, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[1] = {1'b1, 1'b1, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2] = {1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[3] = {1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'hA5};
        vt[4] = {1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[5] = {1'b0, 1'b1, 8'h5A, 5'd2, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[6] = {1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 8'hA5};
        frame_len = 20;
        for (int i = 0; i < 7; i++) begin
            rst      = vt[i].r;
            wr_valid = vt[i].v;
            wr_data  = vt[i].d;
            tick();
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].emp));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].ful));
            check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(!vt[i].ful));
            check($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(vt[i].ts));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vt[i].td));
        end
        rst = 0;
        drain(200);
        exp_q = '{8'hA5, 8'h3C, 8'h5A};
        check_sent("vec_drain", exp_q);

        // ordering over a burst
        reset_dut();
        frame_len = 20;
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1;
            wr_data  = 8'(i);
            tick();
        end
        drain(400);
        check("ordering_launches", 32'(launches), 32'd5);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_sent("ordering", exp_q);

        // overflow with a stalled transmitter
        reset_dut();
        stall = 1;
        for (int i = 0; i < 18; i++) begin
            wr_valid = 1;
            wr_data  = 8'h10 + 8'(i);
            tick();
        end
        wr_valid = 0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_wr_ready", 32'(wr_ready), 32'd0);
        drain(1000);
        exp_q.delete();
        for (int i = 0; i < 17; i++) exp_q.push_back(8'h10 + 8'(i));
        check_sent("overflow", exp_q);

        // push coinciding with a pop at count 15, then random traffic with wrap-around
        reset_dut();
        frame_len = 4;
        stall = 1;
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1;
            wr_data  = 8'h40 + 8'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_valid = 0;
        stall = 0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            found = expect_launch && (m_q.size() == DEPTH - 1);
        end
        check("coincide_reached", 32'(found), 32'd1);
        wr_valid = 1;
        wr_data  = 8'hEE;
        exp_q.push_back(wr_data);
        tick();
        wr_valid = 0;
        check("coincide_count", 32'(count), 32'd15);
        check("coincide_launch", 32'(tx_start), 32'd1);
        total = 18;
        for (int k = 0; k < 4000 && total < 3 * DEPTH; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) stall = !stall;
            acc_pred = wr_valid && (m_q.size() < DEPTH);
            if (acc_pred) begin
                exp_q.push_back(wr_data);
                total++;
                frame_len = $urandom_range(1, 4);
            end
            tick();
        end
        check("random_total", 32'(total), 32'(3 * DEPTH));
        drain(2000);
        check_sent("wrap_random", exp_q);

        // reset while the transmitter is mid-frame
        reset_dut();
        frame_len = 20;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1;
            wr_data  = 8'hE1 + 8'(i);
            tick();
        end
        wr_valid = 0;
        n = 0;
        while (xmt_t < 3 && n < 50) begin
            tick();
            n++;
        end
        check("midframe_reached", 32'(xmt_t >= 3), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_tx_start", 32'(tx_start), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data), 32'd0);
        base = launches;
        n = 0;
        while (xmt_run && n < 100) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) tick();
        check("stray_frame_ended", 32'(xmt_run), 32'd0);
        check("no_launch_after_reset", 32'(launches), 32'(base));
        exp_q = '{8'hE1};
        check_sent("rst_mid", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1);
    end

endmodule
